rle_packer: RTL and testbench
=============================

# rle_packer

Run-length packer that sits directly downstream of the data compressor. It consumes the compressor's 8-bit output stream, which is full of repeated characters wherever hold was asserted. Consecutive identical bytes are collapsed into {symbol, run-length} tokens. Tokens are buffered in a small FIFO and released to the next stage under a valid/ready handshake. Upstream backpressure goes through rdyo.

## Interface
- CNT_W, 8: run-length field width; maximum run length is 2^CNT_W-1.
- FIFO_DEPTH, 4: token FIFO entries; must be a power of 2, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  8  byte from the compressor's dout.
- vldi  in  1  din valid; driven by the compressor's vldo.
- flush  in  1  single-cycle pulse; terminates and emits the open run.
- rdyo  out  1  packer can accept a byte this cycle.
- sym  out  8  token symbol, taken from the FIFO head.
- run  out  CNT_W  token run length, 1 to 2^CNT_W-1, taken from the FIFO head.
- vldo  out  1  token valid; equals FIFO not-empty.
- rdyi  in  1  downstream accepts the token.
- busy  out  1  high when a run is open, the FIFO is non-empty, or a flush is pending.

## Operation
- Run state:
  - active flag, cur_sym[7:0], cur_cnt[CNT_W-1:0].
  - Reset: active=0, cur_sym=0, cur_cnt=0.
- Byte accept is acc = vldi & rdyo.
  - rdyo = !full & !flush_pend.
  - Bytes with vldi=0 are ignored.
- On acc:
  - If !active: cur_sym=din, cur_cnt=1, active=1.
  - Else if din==cur_sym and cur_cnt != 2^CNT_W-1: cur_cnt=cur_cnt+1.
  - Else, on a mismatch or a saturated count: push {cur_sym, cur_cnt}, then cur_sym=din and cur_cnt=1.
- Flush:
  - A flush pulse sets flush_pend.
  - Flush executes on the first cycle with flush_pend=1 and !full.
  - If active, execution pushes {cur_sym, cur_cnt}.
  - Execution always clears active and flush_pend.
  - Flushing while idle pushes nothing.
- flush and acc in the same cycle: the byte is processed first, and the following flush includes it.
- A flush pulse while flush_pend=1 is absorbed. No second token is produced.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full means the indices match and the MSBs differ. empty means the pointers are equal.
  - Pop = vldo & rdyi.
  - Push and pop in the same cycle are both allowed. A push never occurs when full because rdyo and flush are gated by full.
  - Push+pop while full cannot happen. Pop alone while full frees a slot; rdyo rises the following cycle.
- sym and run are a combinational read of the registered storage at rd_ptr.
  - They are stable while vldo=1 and rdyi=0.
  - Token order is strictly byte-arrival order.
- Reset mid-operation discards the open run, FIFO contents, and any pending flush.

## Timing
- Reset values:
  - vldo=0, sym=0, run=0 (storage cleared), busy=0.
  - rdyo=1 in the first cycle after rst deasserts.
- Token latency: a byte accepted at edge N that terminates a run makes that run's token visible (vldo=1) right after edge N, provided the FIFO was empty.
- Flush latency: a flush sampled at edge N with FIFO not full pushes the token at edge N+1. rdyo is low for the cycle between N and N+1.
- Throughput: 1 byte per cycle while not full. One token is popped per cycle with rdyi=1.
- The open run is never emitted without a terminating byte, a saturation, or a flush.

## Test plan
- Basic runs: bytes 3F,0F,0F,8F, then flush, rdyi=1. Tokens must be (3F,1), (0F,2), (8F,1). busy=0 afterwards.
- Saturation, CNT_W=8: 256 consecutive AA, then flush. Tokens must be (AA,255), (AA,1).
- Backpressure, FIFO_DEPTH=4, rdyi=0: bytes 01..06 offered back-to-back.
  - Accepting 02..05 pushes (01,1)..(04,1); rdyo=0 once full, with 06 stalled.
  - Raising rdyi must drain (01,1)..(04,1) in order.
  - 06 must be accepted one cycle after the first pop.
- Flush collision: byte 5A accepted on the same cycle as a flush pulse, with an open run 5A×3. Token must be (5A,4). rdyo=0 for exactly one cycle.
- Idle flush: flush with no open run and the FIFO empty. No token, vldo stays 0.
- Reset mid-run: feed 11,11,22 with rdyi=0, then pulse rst.
  - vldo=0, busy=0, rdyo=1 immediately after.
  - A subsequent 33 then flush yields only (33,1).

Source files
------------

// File: rtl/rle_packer_if.sv
// Byte-stream and token-stream handshake bundle for rle_packer.
// The master side feeds bytes and accepts tokens; the slave side is the packer.
interface rle_packer_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       din;
  logic             vldi;
  logic             flush;
  logic             rdyo;
  logic [7:0]       sym;
  logic [CNT_W-1:0] run;
  logic             vldo;
  logic             rdyi;
  logic             busy;

  modport master (
    output din, vldi, flush, rdyi,
    input  rdyo, sym, run, vldo, busy
  );

  modport slave (
    input  din, vldi, flush, rdyi,
    output rdyo, sym, run, vldo, busy
  );
endinterface

// File: rtl/rle_packer.sv
// Run-length packer: collapses repeated bytes into {symbol, run-length} tokens
// and releases them through a small token FIFO under valid/ready.
//
// state  | meaning
// S_IDLE | no open run
// S_RUN  | run open in cur_sym/cur_cnt
module rle_packer #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  rle_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cur_sym, cur_sym_nxt;
  logic [CNT_W-1:0] cur_cnt, cur_cnt_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic             push;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [7:0]       sym_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] run_mem [FIFO_DEPTH];

  logic full, empty, acc, pop, flush_exec;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.rdyo   = !full && !flush_pend;
  assign acc        = bus.vldi && bus.rdyo;
  assign pop        = !empty && bus.rdyi;
  // acc requires !flush_pend, so it never coincides with a flush execution
  assign flush_exec = flush_pend && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_sym    <= '0;
      cur_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_sym    <= cur_sym_nxt;
      cur_cnt    <= cur_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_sym_nxt    = cur_sym;
    cur_cnt_nxt    = cur_cnt;
    flush_pend_nxt = flush_pend;
    push           = 1'b0;
    if (flush_exec) begin
      // a flush pulse arriving on the execution cycle is absorbed
      flush_pend_nxt = 1'b0;
      state_nxt      = S_IDLE;
      push           = (state == S_RUN);
    end else begin
      if (bus.flush) flush_pend_nxt = 1'b1;
      if (acc) begin
        if (state == S_IDLE) begin
          cur_sym_nxt = bus.din;
          cur_cnt_nxt = CNT_ONE;
          state_nxt   = S_RUN;
        end else if (bus.din == cur_sym && cur_cnt != CNT_MAX) begin
          cur_cnt_nxt = cur_cnt + CNT_ONE;
        end else begin
          push        = 1'b1;
          cur_sym_nxt = bus.din;
          cur_cnt_nxt = CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        sym_mem[i] <= '0;
        run_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        sym_mem[wr_ptr[AW-1:0]] <= cur_sym;
        run_mem[wr_ptr[AW-1:0]] <= cur_cnt;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.sym  = sym_mem[rd_ptr[AW-1:0]];
  assign bus.run  = run_mem[rd_ptr[AW-1:0]];
  assign bus.vldo = !empty;
  assign bus.busy = (state == S_RUN) || !empty || flush_pend;
endmodule

// File: tb/tb_rle_packer.sv
// Directed bench for rle_packer: expected tokens queued as stimulus is driven,
// compared as the DUT hands each token downstream.
module tb_rle_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rle_packer_if #(.CNT_W(8)) bus ();
  rle_packer #(.CNT_W(8), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_tok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // token scoreboard: every token leaving the DUT must match the queue head
  always @(negedge clk) begin
    if (!rst && bus.vldo && bus.rdyi) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL token_unexpected observed=%h expected=none", {bus.sym, bus.run});
      end else begin
        exp_tok = sb.pop_front();
        assert ({bus.sym, bus.run} === exp_tok) else begin
          fails++;
          $error("FAIL token observed=%h expected=%h", {bus.sym, bus.run}, exp_tok);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.din  = b;
    bus.vldi = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.rdyo;
      step();
      n++;
    end
    bus.vldi = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 500) begin
      step();
      n++;
    end
    chk(tag, {31'd0, (sb.size() == 0) && !bus.busy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.din   = 8'h00;
    bus.vldi  = 1'b0;
    bus.flush = 1'b0;
    bus.rdyi  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_vldo", {31'd0, bus.vldo}, 32'd0);
    chk("rst_sym",  {24'd0, bus.sym},  32'd0);
    chk("rst_run",  {24'd0, bus.run},  32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdyo", {31'd0, bus.rdyo}, 32'd1);

    // basic runs
    bus.rdyi = 1'b1;
    sb.push_back(16'h3F01);
    sb.push_back(16'h0F02);
    sb.push_back(16'h8F01);
    send_byte(8'h3F);
    chk("basic_no_early_token", {31'd0, bus.vldo}, 32'd0);
    send_byte(8'h0F);
    chk("basic_latency_vldo", {31'd0, bus.vldo}, 32'd1);
    chk("basic_latency_tok", {16'd0, bus.sym, bus.run}, 32'h3F01);
    send_byte(8'h0F);
    send_byte(8'h8F);
    pulse_flush();
    drain("basic_drain");

    // saturation
    sb.push_back(16'hAAFF);
    sb.push_back(16'hAA01);
    for (int i = 0; i < 256; i++) send_byte(8'hAA);
    pulse_flush();
    drain("sat_drain");

    // backpressure
    bus.rdyi = 1'b0;
    for (int i = 1; i <= 6; i++) sb.push_back({i[7:0], 8'h01});
    for (int i = 1; i <= 5; i++) send_byte(i[7:0]);
    chk("bp_full_rdyo", {31'd0, bus.rdyo}, 32'd0);
    bus.din  = 8'h06;
    bus.vldi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_rdyo", {31'd0, bus.rdyo}, 32'd0);
      chk("bp_head_stable", {16'd0, bus.sym, bus.run}, 32'h0101);
    end
    bus.rdyi = 1'b1;
    @(negedge clk);
    chk("bp_rdyo_before_pop", {31'd0, bus.rdyo}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_rdyo_after_pop", {31'd0, bus.rdyo}, 32'd1);
    step();
    bus.vldi = 1'b0;
    pulse_flush();
    drain("bp_drain");

    // flush colliding with a byte, plus an absorbed second pulse
    sb.push_back(16'h5A04);
    for (int i = 0; i < 3; i++) send_byte(8'h5A);
    bus.din   = 8'h5A;
    bus.vldi  = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("col_rdyo_accept", {31'd0, bus.rdyo}, 32'd1);
    step();
    bus.vldi = 1'b0;
    @(negedge clk);
    chk("col_rdyo_low", {31'd0, bus.rdyo}, 32'd0);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("col_rdyo_back", {31'd0, bus.rdyo}, 32'd1);
    drain("col_drain");

    // idle flush
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      chk("idle_vldo", {31'd0, bus.vldo}, 32'd0);
      step();
    end
    drain("idle_drain");

    // reset mid-run
    bus.rdyi = 1'b0;
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("mid_token_held", {16'd0, bus.sym, bus.run}, 32'h1102);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vldo", {31'd0, bus.vldo}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rdyo", {31'd0, bus.rdyo}, 32'd1);
    bus.rdyi = 1'b1;
    sb.push_back(16'h3301);
    send_byte(8'h33);
    pulse_flush();
    drain("mid_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
